// File: rtl/ev20_pkg.sv
// Shared EV20 definitions: address width, address type, return-stack default
// depth and the PC incrementer used by both the PC counter and the return stack.
package ev20_pkg;

  localparam int EV20_AW      = 11;
  localparam int RSTACK_DEPTH = 8;

  typedef logic [EV20_AW-1:0] ev20_addr_t;

  // Next sequential address; wraps modulo 2^EV20_AW (7FF -> 000).
  function automatic ev20_addr_t addr_inc(input ev20_addr_t a);
    return a + ev20_addr_t'(1);
  endfunction

endpackage

// File: rtl/ev20_rstack_mem.sv
// Return-stack storage: DEPTH x AW register array with one synchronous write
// port and one asynchronous read port (driven with the top-of-stack index).
module ev20_rstack_mem #(
  parameter int AW    = 11,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [AW-1:0] i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [AW-1:0] o_rdata
);

  logic [AW-1:0] r_mem [DEPTH];

  // Write the addressed entry on a qualified push.
  // NOTE: the array has no reset on purpose; entries are only read after being
  // written, and leaving reset off lets the array map onto plain registers/LUTRAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ev20_return_stack.sv
// EV20 hardware call/return stack. CALL pushes call_pc+1; RET pops it and
// presents it to the PC counter with a one-cycle preload strobe.
// Optional build macro EV20_RSTACK_WRAP_EN: when defined, a push while full
// overwrites the oldest entry (circular stack); otherwise the push is dropped.
// Both cases set the sticky ovf_err flag.
module ev20_return_stack
  import ev20_pkg::*;
#(
  parameter int AW    = EV20_AW,
  parameter int DEPTH = RSTACK_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] call_pc,
  input  logic          err_clr,
  output logic [AW-1:0] ret_addr,
  output logic          preload,
  output logic [PW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf_err,
  output logic          unf_err
);

  logic [PW-1:0] r_sp;
  logic [PW:0]   r_count;
  logic [AW-1:0] r_ret_addr;
  logic          r_preload;
  logic          r_ovf_err;
  logic          r_unf_err;

  logic          w_full;
  logic          w_empty;
  logic [PW-1:0] w_top_idx;
  logic [AW-1:0] w_top_data;
  logic [AW-1:0] w_push_data;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_replace;
  logic          w_pop_unf;
  logic          w_ovf_hit;
  logic          w_wrap;
  logic          w_we;
  logic [PW-1:0] w_waddr;

  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_top_idx = r_sp - PW'(1);

  // Return address computed with the shared incrementer when widths line up.
  generate
    if (AW == EV20_AW) begin : g_pkg_inc
      assign w_push_data = addr_inc(call_pc);
    end else begin : g_local_inc
      assign w_push_data = call_pc + AW'(1);
    end
  endgenerate

  // Classify this cycle's request into mutually exclusive stack operations.
  always_comb begin
    // NOTE: every signal gets a default before the conditional logic so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_push_ok = 1'b0;
    w_pop_ok  = 1'b0;
    w_replace = 1'b0;
    w_pop_unf = 1'b0;
    w_ovf_hit = 1'b0;
    if (push && pop) begin
      if (w_empty) begin
        w_pop_unf = 1'b1;
        w_push_ok = 1'b1;
      end else begin
        w_replace = 1'b1;
      end
    end else if (push) begin
      if (w_full) w_ovf_hit = 1'b1;
      else        w_push_ok = 1'b1;
    end else if (pop) begin
      if (w_empty) w_pop_unf = 1'b1;
      else         w_pop_ok  = 1'b1;
    end
  end

`ifdef EV20_RSTACK_WRAP_EN
  // Circular mode: overflowing push overwrites the oldest entry, which sits at sp.
  assign w_wrap = w_ovf_hit;
`else
  // Drop mode: overflowing push leaves the stack untouched.
  assign w_wrap = 1'b0;
`endif

  assign w_we    = w_push_ok | w_replace | w_wrap;
  assign w_waddr = w_replace ? w_top_idx : r_sp;

  ev20_rstack_mem #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_push_data),
    .i_raddr (w_top_idx),
    .o_rdata (w_top_data)
  );

  // Stack pointer, occupancy, popped address/strobe and sticky error flags.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sp       <= '0;
      r_count    <= '0;
      r_ret_addr <= '0;
      r_preload  <= 1'b0;
      r_ovf_err  <= 1'b0;
      r_unf_err  <= 1'b0;
    end else begin
      r_preload <= w_pop_ok | w_replace;
      if (w_pop_ok || w_replace) begin
        r_ret_addr <= w_top_data;
      end

      if (w_push_ok) begin
        r_sp    <= r_sp + PW'(1);
        r_count <= r_count + (PW+1)'(1);
      end else if (w_wrap) begin
        r_sp <= r_sp + PW'(1);
      end else if (w_pop_ok) begin
        r_sp    <= w_top_idx;
        r_count <= r_count - (PW+1)'(1);
      end

      // A new error in the same cycle as err_clr wins over the clear.
      if (w_ovf_hit)    r_ovf_err <= 1'b1;
      else if (err_clr) r_ovf_err <= 1'b0;
      if (w_pop_unf)    r_unf_err <= 1'b1;
      else if (err_clr) r_unf_err <= 1'b0;
    end
  end

  assign ret_addr = r_ret_addr;
  assign preload  = r_preload;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign ovf_err  = r_ovf_err;
  assign unf_err  = r_unf_err;

endmodule

// File: tb/tb_ev20_return_stack.sv
// Self-checking bench for ev20_return_stack (DEPTH=8, AW=11). A behavioural
// stack model predicts each pop; predicted return addresses are queued when the
// pop is driven and compared when the DUT raises preload.
module tb_ev20_return_stack;

  localparam int AW    = 11;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          res;
  logic          push;
  logic          pop;
  logic [AW-1:0] call_pc;
  logic          err_clr;
  logic [AW-1:0] ret_addr;
  logic          preload;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          ovf_err;
  logic          unf_err;

  ev20_return_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .res      (res),
    .push     (push),
    .pop      (pop),
    .call_pc  (call_pc),
    .err_clr  (err_clr),
    .ret_addr (ret_addr),
    .preload  (preload),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] model[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_ret;
  logic          exp_ovf;
  logic          exp_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compare all outputs against the model state one step after an edge.
  task automatic check_outputs(input logic exp_pre);
    check("preload", preload, exp_pre);
    if (preload) begin
      if (exp_q.size() == 0) begin
        check("spurious_preload", 1, 0);
      end else begin
        exp_ret = exp_q.pop_front();
      end
    end
    check("ret_addr", ret_addr, exp_ret);
    check("count", count, model.size());
    check("full", full, model.size() == DEPTH);
    check("empty", empty, model.size() == 0);
    check("ovf_err", ovf_err, exp_ovf);
    check("unf_err", unf_err, exp_unf);
  endtask

  // Drive one cycle of stimulus at the falling edge, update the model, check after the edge.
  task automatic step(input logic p_push, input logic p_pop, input logic [AW-1:0] pc,
                      input logic clr);
    logic          exp_pre;
    logic [AW-1:0] pc1;
    @(negedge clk);
    push    = p_push;
    pop     = p_pop;
    call_pc = pc;
    err_clr = clr;
    pc1     = pc + 11'd1;
    exp_pre = 1'b0;
    if (clr) begin
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end
    if (p_pop && model.size() > 0) begin
      exp_pre = 1'b1;
      exp_q.push_back(model[$]);
      if (p_push) model[$] = pc1;
      else        void'(model.pop_back());
    end else if (p_pop) begin
      exp_unf = 1'b1;
      if (p_push) model.push_back(pc1);
    end else if (p_push) begin
      if (model.size() < DEPTH) begin
        model.push_back(pc1);
      end else begin
        exp_ovf = 1'b1;
`ifdef EV20_RSTACK_WRAP_EN
        void'(model.pop_front());
        model.push_back(pc1);
`endif
      end
    end
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    check_outputs(exp_pre);
  endtask

  initial begin
    res     = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    call_pc = '0;
    err_clr = 1'b0;
    exp_ret = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #12;
    check_outputs(1'b0);
    @(negedge clk);
    res = 1'b0;

    // Single push/pop.
    step(1, 0, 11'h010, 0);
    step(0, 1, 11'h000, 0);
    check("pop_010", ret_addr, 11'h011);
    step(0, 0, 11'h000, 0);

    // LIFO order.
    step(1, 0, 11'h100, 0);
    step(1, 0, 11'h200, 0);
    step(1, 0, 11'h300, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 11'h000, 0);
    check("lifo_last", ret_addr, 11'h101);
    step(0, 0, 11'h000, 0);

    // Underflow and sticky clear.
    step(0, 1, 11'h000, 0);
    step(0, 0, 11'h000, 0);
    step(0, 0, 11'h000, 1);
    // Clear and new underflow in the same cycle: set wins.
    step(0, 1, 11'h000, 1);
    step(0, 0, 11'h000, 1);

    // Overflow: nine pushes then pop to empty.
    for (int i = 1; i <= 9; i++) step(1, 0, 11'(32'h400 + 16 * i), 0);
    for (int i = 0; i < 8; i++) step(0, 1, 11'h000, 0);
`ifdef EV20_RSTACK_WRAP_EN
    check("ovf_oldest", ret_addr, 11'h421);
`else
    check("ovf_oldest", ret_addr, 11'h411);
`endif
    step(0, 1, 11'h000, 0);
    step(0, 0, 11'h000, 1);

    // Push+pop on empty: push proceeds, underflow flagged.
    step(1, 1, 11'h123, 0);
    step(0, 1, 11'h000, 1);
    check("pp_empty_pop", ret_addr, 11'h124);

    // Push+pop with two entries: replace top.
    step(1, 0, 11'h010, 0);
    step(1, 0, 11'h054, 0);
    step(1, 1, 11'h07F, 0);
    check("replace_ret", ret_addr, 11'h055);
    step(0, 1, 11'h000, 0);
    check("replace_new", ret_addr, 11'h080);
    step(0, 1, 11'h000, 0);

    // Address wrap.
    step(1, 0, 11'h7FF, 0);
    step(0, 1, 11'h000, 0);
    check("wrap_7ff", ret_addr, 11'h000);

    // Random traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           11'($urandom), 1'($urandom_range(0, 7) == 0));

    // Asynchronous reset with three entries and a preload pending.
    step(0, 0, 11'h000, 1);
    while (model.size() > 0) step(0, 1, 11'h000, 0);
    step(1, 0, 11'h201, 0);
    step(1, 0, 11'h202, 0);
    step(1, 0, 11'h203, 0);
    step(1, 0, 11'h204, 0);
    step(0, 1, 11'h000, 0);
    check("pre_reset_preload", preload, 1'b1);
    #2;
    res = 1'b1;
    #1;
    model.delete();
    exp_q.delete();
    exp_ret = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_outputs(1'b0);
    @(negedge clk);
    res = 1'b0;
    step(0, 0, 11'h000, 0);
    step(0, 1, 11'h000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
